// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: ISA opcodes, widths and the
// decoded control bundle carried from decode into execute.
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  // Operand-1 source selection produced by the field decoder.
  typedef enum logic [1:0] {
    OP1_ZERO  = 2'd0,
    OP1_REG   = 2'd1,
    OP1_ALIGN = 2'd2,
    OP1_PC    = 2'd3
  } op1_sel_e;

  typedef struct packed {
    logic [3:0]    opcode;
    logic [RW-1:0] dst;
    logic          we;
    logic          memread;
    logic          memwrite;
    logic          branch;
    logic [2:0]    cond;
  } ctrl_t;

endpackage

// File: rtl/instr_fields.sv
// Pure combinational instruction field decoder: register sources, operand
// selection, immediates and the control bundle for one instruction word.
import cpu_pkg::*;

module instr_fields (
  input  logic [15:0]   i_instr,
  output logic [3:0]    o_src1,
  output logic [3:0]    o_src2,
  output logic          o_uses1,
  output logic          o_uses2,
  output op1_sel_e      o_op1_sel,
  output logic          o_op2_reg,
  output logic [15:0]   o_imm,
  output logic          o_is_store,
  output logic          o_is_hlt,
  output ctrl_t         o_ctrl
);

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs;
  logic [3:0]  w_rt;
  logic [15:0] w_ls_imm;
  logic [15:0] w_br_imm;

  assign w_op     = i_instr[15:12];
  assign w_rd     = i_instr[11:8];
  assign w_rs     = i_instr[7:4];
  assign w_rt     = i_instr[3:0];
  // Memory offsets and branch offsets are halfword counts.
  assign w_ls_imm = {{11{i_instr[3]}}, i_instr[3:0], 1'b0};
  assign w_br_imm = {{6{i_instr[8]}}, i_instr[8:0], 1'b0};

  // Per-opcode field and control decode; unused sources stay at 0.
  always_comb begin
    o_src1     = 4'h0;
    o_src2     = 4'h0;
    o_uses1    = 1'b0;
    o_uses2    = 1'b0;
    o_op1_sel  = OP1_ZERO;
    o_op2_reg  = 1'b0;
    o_imm      = 16'h0000;
    o_is_store = 1'b0;
    o_is_hlt   = 1'b0;
    o_ctrl     = '0;
    o_ctrl.opcode = w_op;
    case (w_op)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        o_src1 = w_rs;  o_uses1 = 1'b1;
        o_src2 = w_rt;  o_uses2 = 1'b1;
        o_op1_sel = OP1_REG;
        o_op2_reg = 1'b1;
        o_ctrl.dst = w_rd;
        o_ctrl.we  = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        o_src1 = w_rs;  o_uses1 = 1'b1;
        o_op1_sel = OP1_REG;
        o_imm = {12'h000, w_rt};
        o_ctrl.dst = w_rd;
        o_ctrl.we  = 1'b1;
      end
      OP_LW: begin
        o_src1 = w_rs;  o_uses1 = 1'b1;
        o_op1_sel = OP1_ALIGN;
        o_imm = w_ls_imm;
        o_ctrl.dst     = w_rd;
        o_ctrl.we      = 1'b1;
        o_ctrl.memread = 1'b1;
      end
      OP_SW: begin
        o_src1 = w_rs;  o_uses1 = 1'b1;
        o_src2 = w_rd;  o_uses2 = 1'b1;
        o_op1_sel = OP1_ALIGN;
        o_imm = w_ls_imm;
        o_is_store = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        o_src1 = w_rd;  o_uses1 = 1'b1;
        o_op1_sel = OP1_REG;
        o_imm = {8'h00, i_instr[7:0]};
        o_ctrl.dst = w_rd;
        o_ctrl.we  = 1'b1;
      end
      OP_B: begin
        o_op1_sel = OP1_PC;
        o_imm = w_br_imm;
        o_ctrl.branch = 1'b1;
        o_ctrl.cond   = i_instr[11:9];
      end
      OP_BR: begin
        o_src1 = w_rs;  o_uses1 = 1'b1;
        o_op1_sel = OP1_REG;
        o_ctrl.branch = 1'b1;
        o_ctrl.cond   = i_instr[11:9];
      end
      OP_PCS: begin
        o_op1_sel = OP1_PC;
        o_ctrl.dst = w_rd;
        o_ctrl.we  = 1'b1;
      end
      OP_HLT: begin
        o_is_hlt = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
    // R0 is hard-wired zero, so a write to it is dropped here.
    o_ctrl.we = o_ctrl.we & (o_ctrl.dst != 4'h0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: operand muxing, load-use hazard detection, the single
// valid/ready pipeline slot toward execute, and the sticky halt flag.
import cpu_pkg::*;

module decode_stage #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  input  logic          flush,
  output logic [RW-1:0] rf_src1,
  output logic [RW-1:0] rf_src2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [3:0]    ex_opcode,
  output logic [DW-1:0] ex_op1,
  output logic [DW-1:0] ex_op2,
  output logic [DW-1:0] ex_stdata,
  output logic [RW-1:0] ex_dst,
  output logic          ex_we,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic [2:0]    ex_cond,
  output logic          ex_branch,
  output logic          halted
);

  logic          w_uses1;
  logic          w_uses2;
  op1_sel_e      w_op1_sel;
  logic          w_op2_reg;
  logic [15:0]   w_imm;
  logic          w_is_store;
  logic          w_is_hlt;
  ctrl_t         w_ctrl;
  logic [15:0]   w_op1;
  logic [15:0]   w_op2;
  logic [15:0]   w_stdata;
  logic          w_adv;
  logic          w_haz;
  logic          w_accept;

  logic          r_valid;
  ctrl_t         r_ctrl;
  logic [15:0]   r_op1;
  logic [15:0]   r_op2;
  logic [15:0]   r_stdata;
  logic          r_halted;

  instr_fields u_fields (
    .i_instr    (if_instr),
    .o_src1     (rf_src1),
    .o_src2     (rf_src2),
    .o_uses1    (w_uses1),
    .o_uses2    (w_uses2),
    .o_op1_sel  (w_op1_sel),
    .o_op2_reg  (w_op2_reg),
    .o_imm      (w_imm),
    .o_is_store (w_is_store),
    .o_is_hlt   (w_is_hlt),
    .o_ctrl     (w_ctrl)
  );

  // Operand and store-data selection from register data, PC or immediate.
  always_comb begin
    w_op1    = 16'h0000;
    w_op2    = 16'h0000;
    w_stdata = 16'h0000;
    case (w_op1_sel)
      OP1_REG:   w_op1 = rf_data1;
      OP1_ALIGN: w_op1 = rf_data1 & 16'hFFFE;
      OP1_PC:    w_op1 = if_pc;
      default:   w_op1 = 16'h0000;
    endcase
    if (w_op2_reg) begin
      w_op2 = rf_data2;
    end else begin
      w_op2 = w_imm;
    end
    if (w_is_store) begin
      w_stdata = rf_data2;
    end else begin
      w_stdata = 16'h0000;
    end
  end

  // A load in the slot stalls any consumer of its destination for one cycle.
  assign w_haz = r_valid && r_ctrl.memread && (r_ctrl.dst != 4'h0) &&
                 ((w_uses1 && (rf_src1 == r_ctrl.dst)) ||
                  (w_uses2 && (rf_src2 == r_ctrl.dst)));
  assign w_adv    = !r_valid || ex_ready;
  assign if_ready = w_adv && !w_haz && !r_halted && !flush && !rst;
  assign w_accept = if_valid && if_ready;

  // Pipeline slot: flush clears, advance loads instruction or bubble, else hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_op1    <= 16'h0000;
      r_op2    <= 16'h0000;
      r_stdata <= 16'h0000;
    end else if (w_adv) begin
      if (w_accept && !w_is_hlt) begin
        r_valid  <= 1'b1;
        r_ctrl   <= w_ctrl;
        r_op1    <= w_op1;
        r_op2    <= w_op2;
        r_stdata <= w_stdata;
      end else begin
        r_valid  <= 1'b0;
        r_ctrl   <= '0;
        r_op1    <= 16'h0000;
        r_op2    <= 16'h0000;
        r_stdata <= 16'h0000;
      end
    end
  end

  // Sticky halt flag, set when HLT is accepted and cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_accept && w_is_hlt) begin
      r_halted <= 1'b1;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_opcode   = r_ctrl.opcode;
  assign ex_op1      = r_op1;
  assign ex_op2      = r_op2;
  assign ex_stdata   = r_stdata;
  assign ex_dst      = r_ctrl.dst;
  assign ex_we       = r_ctrl.we;
  assign ex_memread  = r_ctrl.memread;
  assign ex_memwrite = r_ctrl.memwrite;
  assign ex_cond     = r_ctrl.cond;
  assign ex_branch   = r_ctrl.branch;
  assign halted      = r_halted;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with a small register-file model.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        flush;
  logic [3:0]  rf_src1;
  logic [3:0]  rf_src2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_op1;
  logic [15:0] ex_op2;
  logic [15:0] ex_stdata;
  logic [3:0]  ex_dst;
  logic        ex_we;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [2:0]  ex_cond;
  logic        ex_branch;
  logic        halted;

  logic [15:0] rf [16];
  int n_chk;
  int n_fail;

  assign rf_data1 = rf[rf_src1];
  assign rf_data2 = rf[rf_src2];

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_stdata(ex_stdata), .ex_dst(ex_dst),
    .ex_we(ex_we), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_cond(ex_cond), .ex_branch(ex_branch), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0000; if_pc = 16'h0000;
    flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {15'h0, ex_valid}, 16'h0000);
    check("rst_halted", {15'h0, halted}, 16'h0000);
    check("rst_op1", ex_op1, 16'h0000);
    check("rst_ready", {15'h0, if_ready}, 16'h0000);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {15'h0, if_ready}, 16'h0001);

    // ADD R1 = R2 + R3
    rf[2] = 16'h0005; rf[3] = 16'h0007;
    if_instr = 16'h0123; if_valid = 1'b1;
    #1;
    check("add_src1", {12'h0, rf_src1}, 16'h0002);
    check("add_src2", {12'h0, rf_src2}, 16'h0003);
    tick();
    if_valid = 1'b0;
    check("add_valid", {15'h0, ex_valid}, 16'h0001);
    check("add_opcode", {12'h0, ex_opcode}, 16'h0000);
    check("add_op1", ex_op1, 16'h0005);
    check("add_op2", ex_op2, 16'h0007);
    check("add_dst", {12'h0, ex_dst}, 16'h0001);
    check("add_we", {15'h0, ex_we}, 16'h0001);

    // LW RA, -1(R3) followed by a dependent ADD
    rf[3] = 16'h1001; rf[10] = 16'h00AA;
    if_instr = 16'h8A3F; if_valid = 1'b1;
    tick();
    check("lw_op1", ex_op1, 16'h1000);
    check("lw_op2", ex_op2, 16'hFFFE);
    check("lw_memread", {15'h0, ex_memread}, 16'h0001);
    check("lw_dst", {12'h0, ex_dst}, 16'h000A);
    if_instr = 16'h01A2;
    #1;
    check("haz_ready", {15'h0, if_ready}, 16'h0000);
    tick();
    check("bubble_valid", {15'h0, ex_valid}, 16'h0000);
    check("after_haz_ready", {15'h0, if_ready}, 16'h0001);
    tick();
    if_valid = 1'b0;
    check("dep_valid", {15'h0, ex_valid}, 16'h0001);
    check("dep_op1", ex_op1, 16'h00AA);
    check("dep_op2", ex_op2, 16'h0005);
    check("dep_memread", {15'h0, ex_memread}, 16'h0000);

    // B with cond 001 at PC 0x0040
    if_instr = 16'hC3FF; if_pc = 16'h0040; if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    check("b_op1", ex_op1, 16'h0040);
    check("b_op2", ex_op2, 16'hFFFE);
    check("b_cond", {13'h0, ex_cond}, 16'h0001);
    check("b_branch", {15'h0, ex_branch}, 16'h0001);
    check("b_we", {15'h0, ex_we}, 16'h0000);

    // LHB R5, 0xC4 then hold the slot for three cycles
    rf[5] = 16'h1234;
    if_instr = 16'hB5C4; if_valid = 1'b1;
    tick();
    check("lhb_op1", ex_op1, 16'h1234);
    check("lhb_op2", ex_op2, 16'h00C4);
    check("lhb_dst", {12'h0, ex_dst}, 16'h0005);
    ex_ready = 1'b0; if_instr = 16'h0123; rf[5] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", {15'h0, if_ready}, 16'h0000);
      tick();
      check("hold_op1", ex_op1, 16'h1234);
      check("hold_valid", {15'h0, ex_valid}, 16'h0001);
    end
    ex_ready = 1'b1; if_valid = 1'b0;
    tick();
    check("drain_valid", {15'h0, ex_valid}, 16'h0000);

    // SW RA, 1(R3)
    rf[3] = 16'h1001; rf[10] = 16'hBEEF;
    if_instr = 16'h9A31; if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    check("sw_op1", ex_op1, 16'h1000);
    check("sw_op2", ex_op2, 16'h0002);
    check("sw_stdata", ex_stdata, 16'hBEEF);
    check("sw_memwrite", {15'h0, ex_memwrite}, 16'h0001);
    check("sw_we", {15'h0, ex_we}, 16'h0000);

    // Flush clears a valid slot even when execute is stalled
    if_instr = 16'h0123; if_valid = 1'b1;
    tick();
    check("pre_flush_valid", {15'h0, ex_valid}, 16'h0001);
    flush = 1'b1; ex_ready = 1'b0;
    #1;
    check("flush_ready", {15'h0, if_ready}, 16'h0000);
    tick();
    flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    check("flush_valid", {15'h0, ex_valid}, 16'h0000);

    // HLT
    if_instr = 16'hF000; if_valid = 1'b1;
    #1;
    check("hlt_ready", {15'h0, if_ready}, 16'h0001);
    tick();
    check("hlt_halted", {15'h0, halted}, 16'h0001);
    check("hlt_valid", {15'h0, ex_valid}, 16'h0000);
    check("hlt_ready_low", {15'h0, if_ready}, 16'h0000);
    tick();
    check("hlt_sticky", {15'h0, halted}, 16'h0001);
    if_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hlt_rst", {15'h0, halted}, 16'h0000);

    // HLT together with flush is not accepted
    if_instr = 16'hF000; if_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    check("hlt_flush_halted", {15'h0, halted}, 16'h0000);
    #1;
    check("hlt_flush_ready", {15'h0, if_ready}, 16'h0001);

    // ADD to R0 drops the write, then reset with a valid slot
    if_instr = 16'h0012; if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    check("r0_valid", {15'h0, ex_valid}, 16'h0001);
    check("r0_we", {15'h0, ex_we}, 16'h0000);
    rst = 1'b1;
    tick();
    check("rst2_valid", {15'h0, ex_valid}, 16'h0000);
    check("rst2_op1", ex_op1, 16'h0000);
    check("rst2_op2", ex_op2, 16'h0000);
    check("rst2_dst", {12'h0, ex_dst}, 16'h0000);
    check("rst2_opcode", {12'h0, ex_opcode}, 16'h0000);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
